// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-in / parallel-out deserializer.
package sipo_pkg;

  typedef enum logic {
    SHIFT = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Accepted-bit counter: counts on en, clears on clr (clr wins), flags the terminal count.
module sipo_bit_counter #(
  parameter int W    = 4,
  parameter int TERM = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [W-1:0] TC_VAL = W'(TERM);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with a valid/ready word handshake.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit and expose po_parity_err.
import sipo_pkg::*;

module sipo_deserializer #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         SI,
  input  logic         si_valid,
  output logic         si_ready,
  output logic [N-1:0] PO,
  output logic         po_valid,
  input  logic         po_ready
`ifdef SIPO_PARITY_EN
  ,
  output logic         po_parity_err
`endif
);

`ifdef SIPO_PARITY_EN
  localparam int WL = N + 1;
`else
  localparam int WL = N;
`endif
  localparam int CW = cnt_w(N);

  state_t       state;
  logic [N-1:0] sr;
  logic [N-1:0] word;
  logic         tc;
  logic         accept;
  logic         last;
  logic         sr_shift;

  function automatic logic [N-1:0] shift_in(input logic [N-1:0] v, input logic b);
    if (MSB_FIRST != 0) return {v[N-2:0], b};
    else                return {b, v[N-1:1]};
  endfunction

  assign si_ready = (state == SHIFT);
  assign accept   = si_valid && si_ready;
  assign last     = accept && tc;

  // The parity bit never enters the data register; the word is whatever was shifted before it.
`ifdef SIPO_PARITY_EN
  assign sr_shift = accept && !last;
  assign word     = sr;
`else
  assign sr_shift = accept;
  assign word     = shift_in(sr, SI);
`endif

  sipo_bit_counter #(
    .W    (CW),
    .TERM (WL - 1)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .clr   (last),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SHIFT;
      sr       <= '0;
      PO       <= '0;
      po_valid <= 1'b0;
`ifdef SIPO_PARITY_EN
      po_parity_err <= 1'b0;
`endif
    end else begin
      if (sr_shift) sr <= shift_in(sr, SI);
      case (state)
        SHIFT: begin
          if (last) begin
            PO       <= word;
            po_valid <= 1'b1;
            state    <= FULL;
`ifdef SIPO_PARITY_EN
            po_parity_err <= ^{sr, SI};
`endif
          end
        end
        FULL: begin
          if (po_ready) begin
            po_valid <= 1'b0;
            state    <= SHIFT;
          end
        end
        default: state <= SHIFT;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: one MSB-first and one LSB-first instance share the same stimulus.
module tb_sipo_deserializer;

  localparam int N = 8;
`ifdef SIPO_PARITY_EN
  localparam int WL = N + 1;
`else
  localparam int WL = N;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         SI = 1'b0;
  logic         si_valid = 1'b0;
  logic         po_ready = 1'b0;
  logic         si_ready_m, si_ready_l;
  logic         po_valid_m, po_valid_l;
  logic [N-1:0] po_m, po_l;
`ifdef SIPO_PARITY_EN
  logic         err_m, err_l;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.N(N), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .SI(SI), .si_valid(si_valid), .si_ready(si_ready_m),
    .PO(po_m), .po_valid(po_valid_m), .po_ready(po_ready)
`ifdef SIPO_PARITY_EN
    , .po_parity_err(err_m)
`endif
  );

  sipo_deserializer #(.N(N), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .SI(SI), .si_valid(si_valid), .si_ready(si_ready_l),
    .PO(po_l), .po_valid(po_valid_l), .po_ready(po_ready)
`ifdef SIPO_PARITY_EN
    , .po_parity_err(err_l)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 is MSB-first, index 1 is LSB-first.
  int           mcnt [2];
  logic         mbits[2][WL];
  logic         mfull[2];
  logic [N-1:0] mpo  [2];
  logic         merr [2];

  always @(posedge clk) begin : model
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mcnt[d]  = 0;
        mfull[d] = 1'b0;
        mpo[d]   = '0;
        merr[d]  = 1'b0;
      end else if (mfull[d]) begin
        if (po_ready) mfull[d] = 1'b0;
      end else if (si_valid) begin
        mbits[d][mcnt[d]] = SI;
        mcnt[d]++;
        if (mcnt[d] == WL) begin
          logic [N-1:0] w;
          logic         p;
          w = '0;
          p = 1'b0;
          for (int i = 0; i < N; i++) begin
            if (d == 0) w[N-1-i] = mbits[d][i];
            else        w[i]     = mbits[d][i];
          end
          for (int i = 0; i < WL; i++) p = p ^ mbits[d][i];
          mpo[d]   = w;
          merr[d]  = p;
          mfull[d] = 1'b1;
          mcnt[d]  = 0;
        end
      end
    end
  end

  always @(posedge clk) begin : compare
    #1;
    check("si_ready_m", {31'b0, si_ready_m}, {31'b0, !mfull[0]});
    check("si_ready_l", {31'b0, si_ready_l}, {31'b0, !mfull[1]});
    check("po_valid_m", {31'b0, po_valid_m}, {31'b0, mfull[0]});
    check("po_valid_l", {31'b0, po_valid_l}, {31'b0, mfull[1]});
    check("PO_m", {24'b0, po_m}, {24'b0, mpo[0]});
    check("PO_l", {24'b0, po_l}, {24'b0, mpo[1]});
`ifdef SIPO_PARITY_EN
    check("err_m", {31'b0, err_m}, {31'b0, merr[0]});
    check("err_l", {31'b0, err_l}, {31'b0, merr[1]});
`endif
  end

  task automatic drive(input logic v, input logic b, input logic r);
    @(negedge clk);
    rst_n    = 1'b1;
    si_valid = v;
    SI       = b;
    po_ready = r;
  endtask

  // s[7] is the first serial bit; p is the trailing parity bit when parity is compiled in.
  task automatic send_word(input logic [7:0] s, input logic p, input bit gap);
    logic seq[WL];
    for (int i = 0; i < N; i++) seq[i] = s[7-i];
    if (WL > N) seq[WL-1] = p;
    for (int i = 0; i < WL; i++) begin
      drive(1'b1, seq[i], 1'b1);
      if (gap && i < WL - 1) drive(1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic expect_word(input string tag, input logic [7:0] em, input logic [7:0] el);
    drive(1'b0, 1'b0, 1'b1);
    check({tag, "_vld"}, {31'b0, po_valid_m}, 32'd1);
    check({tag, "_PO_m"}, {24'b0, po_m}, {24'b0, em});
    check({tag, "_PO_l"}, {24'b0, po_l}, {24'b0, el});
    drive(1'b0, 1'b0, 1'b1);
    check({tag, "_vld_drop"}, {31'b0, po_valid_m}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_PO", {24'b0, po_m}, 32'h0);
    check("rst_vld", {31'b0, po_valid_m}, 32'd0);
    check("rst_rdy", {31'b0, si_ready_m}, 32'd1);

    send_word(8'b1010_0101, 1'b0, 1'b0);
    expect_word("a5", 8'hA5, 8'hA5);

    send_word(8'b1100_0000, 1'b0, 1'b0);
    expect_word("c0", 8'hC0, 8'h03);

    // Back-pressure: word held for 10 cycles while serial data keeps offering bits.
    send_word(8'b1010_0101, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom & 1), 1'b0);
      check("bp_rdy", {31'b0, si_ready_m}, 32'd0);
      check("bp_vld", {31'b0, po_valid_m}, 32'd1);
      check("bp_PO", {24'b0, po_m}, 32'hA5);
    end
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    check("bp_release", {31'b0, po_valid_m}, 32'd0);

    // Mid-word reset, asserted together with a valid bit.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; si_valid = 1'b1; SI = 1'b0; po_ready = 1'b1;
    send_word(8'hFF, 1'b0, 1'b0);
    expect_word("ff", 8'hFF, 8'hFF);

    send_word(8'b0110_1001, 1'b0, 1'b1);
    expect_word("gap", 8'h69, 8'h96);

`ifdef SIPO_PARITY_EN
    send_word(8'hA5, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    check("par_ok", {31'b0, err_m}, 32'd0);
    send_word(8'hA5, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    check("par_bad", {31'b0, err_m}, 32'd1);
    check("par_bad_PO", {24'b0, po_m}, 32'hA5);
`endif

    // Random traffic with occasional resets, checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n    = ($urandom_range(249, 0) != 0);
      si_valid = ($urandom_range(3, 0) != 0);
      SI       = 1'($urandom & 1);
      po_ready = ($urandom_range(2, 0) != 0);
    end

    drive(1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
